// File: rtl/conflict_serializer_mt.sv
// conflict_serializer_mt: age-ordered ready list that issues tasks to worker threads,
// letting at most one task per locale be runnable or running at any time.
module conflict_serializer_mt #(
  parameter int DEPTH     = 16,
  parameter int N_THREADS = 8,
  parameter int LOCALE_W  = 32,
  parameter int TTYPE_W   = 4,
  parameter int DATA_W    = 128,
  parameter int AF_MARGIN = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [LOCALE_W-1:0]          enq_locale,
  input  logic [TTYPE_W-1:0]           enq_ttype,
  input  logic [DATA_W-1:0]            enq_data,
  input  logic [2**TTYPE_W-1:0]        deq_ttype_mask,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [LOCALE_W-1:0]          deq_locale,
  output logic [TTYPE_W-1:0]           deq_ttype,
  output logic [DATA_W-1:0]            deq_data,
  output logic [$clog2(N_THREADS)-1:0] deq_thread,
  input  logic                         unlock_valid,
  input  logic [$clog2(N_THREADS)-1:0] unlock_thread,
  input  logic [$clog2(DEPTH):0]       cfg_full_thr,
  input  logic [$clog2(N_THREADS):0]   cfg_active_threads,
  output logic                         almost_full,
  output logic                         idle,
  output logic [$clog2(DEPTH):0]       occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(N_THREADS);
  logic [AW:0]          r_occ, w_occ_nx, w_wpos, w_lim;
  logic [DEPTH-1:0]     r_conf, w_conf_c, w_conf_nx;
  logic [LOCALE_W-1:0]  r_loc [DEPTH];
  logic [LOCALE_W-1:0]  w_loc_nx [DEPTH];
  logic [TTYPE_W-1:0]   r_tt [DEPTH];
  logic [TTYPE_W-1:0]   w_tt_nx [DEPTH];
  logic [DATA_W-1:0]    r_data [DEPTH];
  logic [DATA_W-1:0]    w_data_nx [DEPTH];
  logic [N_THREADS-1:0] r_busy;
  logic [LOCALE_W-1:0]  r_tloc [N_THREADS];
  logic                 r_af;
  logic [AW-1:0]        w_sel, w_clr;
  logic [TW-1:0]        w_thr;
  logic                 w_elig, w_clr_hit, w_free, w_lhit, w_unl, w_issue, w_enq;

  assign w_unl       = unlock_valid & r_busy[unlock_thread];
  assign w_lim       = (cfg_full_thr > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : cfg_full_thr;
  assign enq_ready   = r_occ < w_lim;
  assign w_enq       = enq_valid & enq_ready;
  assign deq_valid   = w_elig & w_free;
  assign w_issue     = deq_valid & deq_ready;
  assign w_wpos      = r_occ - (AW+1)'(w_issue);
  assign w_occ_nx    = w_wpos + (AW+1)'(w_enq);
  assign deq_locale  = r_loc[w_sel];
  assign deq_ttype   = r_tt[w_sel];
  assign deq_data    = r_data[w_sel];
  assign deq_thread  = w_thr;
  assign almost_full = r_af;
  assign occupancy   = r_occ;
  assign idle        = (r_occ == '0) & ~|r_busy;

  // Entries are kept compacted with index 0 oldest, so every scan favours the lowest index.
  always_comb begin
    w_elig = 1'b0;
    w_sel = '0;
    w_clr_hit = 1'b0;
    w_clr = '0;
    w_lhit = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (i < int'(r_occ)) begin
        if (!r_conf[i] && deq_ttype_mask[r_tt[i]]) begin
          w_elig = 1'b1;
          w_sel = AW'(i);
        end
        if (r_conf[i] && r_loc[i] == r_tloc[unlock_thread]) begin
          w_clr_hit = 1'b1;
          w_clr = AW'(i);
        end
        if (r_loc[i] == enq_locale) w_lhit = 1'b1;
      end
    end
    w_free = 1'b0;
    w_thr = '0;
    for (int t = N_THREADS-1; t >= 0; t--) begin
      if (!r_busy[t] && t < int'(cfg_active_threads)) begin
        w_free = 1'b1;
        w_thr = TW'(t);
      end
      if (r_busy[t] && r_tloc[t] == enq_locale && !(w_unl && unlock_thread == TW'(t))) w_lhit = 1'b1;
    end
    w_conf_c = r_conf;
    if (w_unl && w_clr_hit) w_conf_c[w_clr] = 1'b0;
  end

  // Issue closes the gap at w_sel; an accepted task lands just past the survivors.
  always_comb begin
    w_conf_nx = w_conf_c;
    w_loc_nx = r_loc;
    w_tt_nx = r_tt;
    w_data_nx = r_data;
    for (int i = 0; i < DEPTH-1; i++) begin
      if (w_issue && i >= int'(w_sel)) begin
        w_conf_nx[i] = w_conf_c[i+1];
        w_loc_nx[i] = r_loc[i+1];
        w_tt_nx[i] = r_tt[i+1];
        w_data_nx[i] = r_data[i+1];
      end
    end
    if (w_enq) begin
      w_conf_nx[w_wpos[AW-1:0]] = w_lhit;
      w_loc_nx[w_wpos[AW-1:0]] = enq_locale;
      w_tt_nx[w_wpos[AW-1:0]] = enq_ttype;
      w_data_nx[w_wpos[AW-1:0]] = enq_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_occ <= '0;
      r_conf <= '0;
      r_busy <= '0;
      r_af <= 1'b0;
    end else begin
      r_occ <= w_occ_nx;
      r_conf <= w_conf_nx;
      r_af <= int'(w_occ_nx) >= DEPTH - AF_MARGIN;
      r_busy <= (r_busy & ~(N_THREADS'(w_unl) << unlock_thread)) | (N_THREADS'(w_issue) << w_thr);
    end
  end

  always_ff @(posedge clk) begin
    r_loc <= w_loc_nx;
    r_tt <= w_tt_nx;
    r_data <= w_data_nx;
    if (w_issue) r_tloc[w_thr] <= deq_locale;
  end
endmodule

// File: tb/tb_conflict_serializer_mt.sv
// tb_conflict_serializer_mt: directed stimulus checked against a queue-based model of the
// ready list and thread pool, plus hand-computed literal checks.
module tb_conflict_serializer_mt;
  logic         clk, rstn, enq_valid, enq_ready, deq_valid, deq_ready, unlock_valid;
  logic         almost_full, idle;
  logic [31:0]  enq_locale, deq_locale;
  logic [3:0]   enq_ttype, deq_ttype, cfg_active_threads;
  logic [127:0] enq_data, deq_data;
  logic [15:0]  deq_ttype_mask;
  logic [2:0]   deq_thread, unlock_thread;
  logic [4:0]   cfg_full_thr, occupancy;
  int n_cmp = 0;
  int n_err = 0;

  conflict_serializer_mt dut (
    .clk(clk), .rstn(rstn), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_locale(enq_locale), .enq_ttype(enq_ttype), .enq_data(enq_data),
    .deq_ttype_mask(deq_ttype_mask), .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_locale(deq_locale), .deq_ttype(deq_ttype), .deq_data(deq_data),
    .deq_thread(deq_thread), .unlock_valid(unlock_valid), .unlock_thread(unlock_thread),
    .cfg_full_thr(cfg_full_thr), .cfg_active_threads(cfg_active_threads),
    .almost_full(almost_full), .idle(idle), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {logic [31:0] loc; logic [3:0] tt; logic [127:0] data;} ent_t;
  ent_t q[$];
  bit          mbusy [8];
  logic [31:0] mloc [8];
  int e_idx, e_thr;
  bit e_dv, e_er, iss, acc;

  function automatic bit blocked(int i);
    for (int j = 0; j < i; j++) if (q[j].loc == q[i].loc) return 1'b1;
    for (int t = 0; t < 8; t++) if (mbusy[t] && mloc[t] == q[i].loc) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit any_busy();
    for (int t = 0; t < 8; t++) if (mbusy[t]) return 1'b1;
    return 1'b0;
  endfunction

  // Model: a task is runnable iff no older task and no running thread shares its locale.
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        q.delete();
        for (int t = 0; t < 8; t++) mbusy[t] = 1'b0;
      end
      e_idx = -1;
      for (int i = 0; i < q.size(); i++)
        if (e_idx < 0 && deq_ttype_mask[q[i].tt] && !blocked(i)) e_idx = i;
      e_thr = -1;
      for (int t = 0; t < 8; t++)
        if (e_thr < 0 && !mbusy[t] && t < int'(cfg_active_threads)) e_thr = t;
      e_dv = e_idx >= 0 && e_thr >= 0;
      e_er = q.size() < ((int'(cfg_full_thr) < 16) ? int'(cfg_full_thr) : 16);
      chk("deq_valid", deq_valid, e_dv);
      if (e_dv) begin
        chk("deq_locale", deq_locale, q[e_idx].loc);
        chk("deq_ttype", deq_ttype, q[e_idx].tt);
        chk("deq_data", deq_data, q[e_idx].data);
        chk("deq_thread", deq_thread, e_thr);
      end
      chk("enq_ready", enq_ready, e_er);
      chk("occupancy", occupancy, q.size());
      chk("almost_full", almost_full, q.size() >= 12);
      chk("idle", idle, q.size() == 0 && !any_busy());
      @(posedge clk);
      if (rstn) begin
        iss = e_dv && deq_ready;
        acc = enq_valid && e_er;
        if (unlock_valid && mbusy[unlock_thread]) mbusy[unlock_thread] = 1'b0;
        if (iss) begin
          mbusy[e_thr] = 1'b1;
          mloc[e_thr] = q[e_idx].loc;
          q.delete(e_idx);
        end
        if (acc) q.push_back('{enq_locale, enq_ttype, enq_data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] l, input logic [3:0] t);
    enq_valid = 1'b1;
    enq_locale = l;
    enq_ttype = t;
    enq_data = {l, ~l, l ^ 32'h5a5a5a5a, 28'h0, t};
  endtask

  task automatic unlock(input logic [2:0] t);
    unlock_valid = 1'b1;
    unlock_thread = t;
  endtask

  task automatic quiet();
    enq_valid = 1'b0;
    unlock_valid = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rstn = 1'b0;
    quiet();
    deq_ready = 1'b1;
    deq_ttype_mask = '1;
    cfg_full_thr = 5'd16;
    cfg_active_threads = 4'd8;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    quiet();
    enq_locale = '0;
    enq_ttype = '0;
    enq_data = '0;
    unlock_thread = '0;
    deq_ready = 1'b1;
    deq_ttype_mask = '1;
    cfg_full_thr = 5'd16;
    cfg_active_threads = 4'd8;
    tick();
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_idle", idle, 1);
    chk("rst_occ", occupancy, 0);
    rstn = 1'b1;
    // A, B, A: second A waits for thread 0 to unlock
    tick(); enq(32'hA, 0);
    tick(); enq(32'hB, 0); #1;
    chk("t1_a_valid", deq_valid, 1); chk("t1_a_loc", deq_locale, 32'hA); chk("t1_a_thr", deq_thread, 0);
    tick(); enq(32'hA, 0); #1;
    chk("t1_b_loc", deq_locale, 32'hB); chk("t1_b_thr", deq_thread, 1);
    tick(); quiet(); #1;
    chk("t1_held", deq_valid, 0); chk("t1_occ", occupancy, 1);
    tick(); unlock(0); #1;
    chk("t1_held_unl", deq_valid, 0);
    tick(); quiet(); #1;
    chk("t1_a2_valid", deq_valid, 1); chk("t1_a2_loc", deq_locale, 32'hA); chk("t1_a2_thr", deq_thread, 0);
    tick(); unlock(0);
    tick(); unlock(1);
    tick(); quiet(); #1;
    chk("t1_idle", idle, 1);
    // type mask selects the younger ttype-2 task
    do_reset();
    tick(); deq_ready = 1'b0; enq(32'd1, 1);
    tick(); enq(32'd2, 2);
    tick(); quiet(); deq_ttype_mask = 16'h0004; deq_ready = 1'b1; #1;
    chk("t2_valid", deq_valid, 1); chk("t2_tt", deq_ttype, 2); chk("t2_loc", deq_locale, 32'd2);
    tick(); #1;
    chk("t2_occ", occupancy, 1); chk("t2_none", deq_valid, 0);
    // two active threads only
    do_reset();
    cfg_active_threads = 4'd2;
    deq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); enq(32'd10 + i, 0);
    end
    tick(); quiet(); deq_ready = 1'b1; #1;
    chk("t3_thr0", deq_thread, 0); chk("t3_loc0", deq_locale, 32'd10);
    tick(); #1;
    chk("t3_thr1", deq_thread, 1); chk("t3_loc1", deq_locale, 32'd11);
    tick(); #1;
    chk("t3_stall", deq_valid, 0); chk("t3_occ", occupancy, 2);
    tick(); unlock(1); #1;
    chk("t3_stall_unl", deq_valid, 0);
    tick(); quiet(); #1;
    chk("t3_thr1b", deq_thread, 1); chk("t3_loc2", deq_locale, 32'd12);
    tick(); cfg_active_threads = 4'd1; unlock(1);
    tick(); quiet(); #1;
    chk("t3_low_active", deq_valid, 0);
    tick(); unlock(0);
    tick(); quiet(); #1;
    chk("t3_thr0b", deq_thread, 0); chk("t3_loc3", deq_locale, 32'd13);
    // fill to the threshold with nothing issuing
    do_reset();
    deq_ready = 1'b0;
    for (int i = 0; i <= 16; i++) begin
      tick(); enq(32'd100 + i, 0); #1;
      chk("t4_occ", occupancy, i);
      chk("t4_enq_ready", enq_ready, i < 16);
      chk("t4_af", almost_full, i >= 12);
    end
    tick(); quiet(); cfg_full_thr = 5'd20; #1;
    chk("t4_occ_full", occupancy, 16); chk("t4_thr_gt_depth", enq_ready, 0);
    // same-cycle unlock and enqueue of the same locale
    do_reset();
    tick(); enq(32'd7, 0);
    tick(); quiet(); #1;
    chk("t5_first", deq_thread, 0);
    tick(); unlock(0); enq(32'd7, 0); #1;
    chk("t5_none", deq_valid, 0);
    tick(); quiet(); #1;
    chk("t5_valid", deq_valid, 1); chk("t5_loc", deq_locale, 32'd7); chk("t5_thr", deq_thread, 0);
    tick(); unlock(5);
    tick(); unlock(0);
    tick(); quiet(); #1;
    chk("t5_idle", idle, 1);
    // reset with 5 held entries and 3 busy threads
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(); enq(32'd20 + i, 0); deq_ready = i < 4;
    end
    tick(); quiet(); #1;
    chk("t6_occ", occupancy, 5); chk("t6_busy", idle, 0);
    #1 rstn = 1'b0;
    #1;
    chk("t6_rst_valid", deq_valid, 0); chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_idle", idle, 1); chk("t6_rst_af", almost_full, 0); chk("t6_rst_ready", enq_ready, 1);
    tick(); deq_ready = 1'b1;
    tick(); rstn = 1'b1; #1;
    chk("t6_release", deq_valid, 0);
    // mixed traffic over a few colliding locales
    for (int i = 0; i < 120; i++) begin
      tick();
      enq_valid = (i % 3) != 2;
      enq_locale = i % 5;
      enq_ttype = 4'(i % 3);
      enq_data = {96'(i), 32'hc0de};
      deq_ttype_mask = (i % 7 == 0) ? 16'h0002 : 16'hffff;
      deq_ready = (i % 4) != 3;
      unlock_valid = i[0];
      unlock_thread = 3'((i / 2) % 4);
    end
    tick(); quiet();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/conflict_serializer_mt.md
CONFLICT_SERIALIZER_MT -- requirements
Module: conflict_serializer_mt

Interface
REQ-001 SHALL have parameter DEPTH, default 16, ready-list entries (power of two, 4..64).
REQ-002 SHALL have parameter N_THREADS, default 8, worker threads (power of two, 2..64).
REQ-003 SHALL have parameter LOCALE_W, default 32, locale width.
REQ-004 SHALL have parameter TTYPE_W, default 4, task-type width.
REQ-005 SHALL have parameter DATA_W, default 128, opaque task payload width.
REQ-006 SHALL have parameter AF_MARGIN, default 4, almost-full margin.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rstn  in  1  reset, asynchronous, active-low.
REQ-009 enq_valid  in  1  producer offers task.
REQ-010 enq_ready  out  1  task accepted when enq_valid & enq_ready.
REQ-011 enq_locale, enq_ttype, enq_data  in  LOCALE_W, TTYPE_W, DATA_W  offered task.
REQ-012 deq_ttype_mask  in  2**TTYPE_W  task types consumer accepts this cycle.
REQ-013 deq_valid  out  1  task issuable.
REQ-014 deq_ready  in  1  consumer takes task when deq_valid & deq_ready.
REQ-015 deq_locale, deq_ttype, deq_data  out  LOCALE_W, TTYPE_W, DATA_W  issued task.
REQ-016 deq_thread  out  log2(N_THREADS)  thread assigned to issued task.
REQ-017 unlock_valid, unlock_thread  in  1, log2(N_THREADS)  thread finished its task.
REQ-018 cfg_full_thr  in  log2(DEPTH)+1  occupancy at which enq_ready drops.
REQ-019 cfg_active_threads  in  log2(N_THREADS)+1  usable threads, 1..N_THREADS.
REQ-020 almost_full, idle  out  1, 1  status.
REQ-021 occupancy  out  log2(DEPTH)+1  valid entries.

Function
REQ-022 Ready list SHALL hold entries in arrival (age) order; each entry holds valid, conflict, locale, ttype and data.
REQ-023 enq_ready SHALL equal (occupancy < min(cfg_full_thr, DEPTH)), combinational from registered state only.
REQ-024 An accepted task SHALL become valid next cycle, with conflict=1 iff a valid entry, or a busy thread not being unlocked this cycle, holds the same locale.
REQ-025 Entry eligible = valid & !conflict & deq_ttype_mask[ttype].
REQ-026 deq_valid SHALL equal (any eligible entry) & (a free thread with index < cfg_active_threads exists).
REQ-027 deq_* outputs SHALL present the oldest eligible entry; deq_thread the lowest-index free thread below cfg_active_threads; both stay stable while deq_ready is low and state is unchanged.
REQ-028 On issue, the entry SHALL be removed (younger entries keep relative order); the thread SHALL be marked busy with that locale from the next cycle.
REQ-029 On unlock_valid of a busy thread, the thread SHALL become free next cycle, and the oldest valid entry with matching locale and conflict=1 SHALL clear conflict next cycle.
REQ-030 Unlock of a non-busy thread SHALL be ignored.
REQ-031 Enqueue, issue and unlock in the same cycle SHALL all take effect; occupancy changes by (enq - issue).
REQ-032 A thread unlocked this cycle SHALL NOT be issued to until the next cycle.
REQ-033 Invariant: per locale, at most one of {busy thread, non-conflict entry} exists.
REQ-034 almost_full SHALL be registered, =1 iff occupancy >= DEPTH - AF_MARGIN.
REQ-035 idle SHALL be 1 iff occupancy == 0 and no thread is busy.
REQ-036 Lowering cfg_active_threads SHALL NOT affect busy threads; their unlocks are still honoured.

Reset
REQ-037 rstn low SHALL asynchronously clear all entry valid/conflict bits and all busy bits.
REQ-038 Reset outputs: deq_valid=0, enq_ready=1 (if cfg_full_thr>0), almost_full=0, idle=1, occupancy=0.
REQ-039 Reset mid-operation SHALL drop all held tasks; no issue occurs in the cycle rstn deasserts.

Verification
REQ-040 Enqueue locales A,B,A (ttype 0), mask all-ones, deq_ready=1 -> issue A(thread 0), B(thread 1); second A held conflict; unlock thread 0 -> second A issues 2 cycles later on thread 0.
REQ-041 Enqueue ttype 1 then ttype 2 (distinct locales), mask=0b0100 -> ttype-2 task issues first; ttype-1 stays, occupancy=1.
REQ-042 cfg_active_threads=2, 4 distinct-locale tasks -> exactly 2 issue (threads 0,1), deq_valid=0 until an unlock.
REQ-043 cfg_full_thr=DEPTH, fill 16 entries with no free thread -> enq_ready=0 at occupancy 16, almost_full=1 from occupancy 12.
REQ-044 Same cycle: unlock thread running locale L, enqueue L with no L in list -> new entry conflict=0, issues next cycle.
REQ-045 Assert rstn low with 5 entries and 3 busy threads -> outputs immediately at reset values, idle=1.
